rs_pipe_sched: RTL

//   Round-robin scheduler sharing one DEPTH-stage, WIDTH-bit register pipeline between NREQ requesters.

---
 rtl/rs_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 39 +++
 rtl/rs_pipe_sched.sv | 109 ++++++++++
 3 files changed

// File: rtl/rs_pkg.sv
// rtl/rs_pkg.sv - shared types and constants for the RS pipeline scheduler
package rs_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 4;

  // Tag width is max(1, clog2(n)) so a two-requester build still carries a tag bit.
  function automatic int tag_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin winner search starting at ptr, wrapping upward
module rr_arbiter
  import rs_pkg::*;
#(
  parameter int  NREQ  = 2,
  localparam int TAG_W = tag_w(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [TAG_W-1:0] ptr,
  input  logic             en,
  output logic [NREQ-1:0]  gnt,
  output logic [TAG_W-1:0] winner
);

  logic hit;

  // First pass covers ptr..NREQ-1, second pass the wrapped range 0..ptr-1.
  always_comb begin
    hit    = 1'b0;
    winner = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!hit && req[i] && (i >= int'(ptr))) begin
        hit    = 1'b1;
        winner = TAG_W'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!hit && req[i]) begin
        hit    = 1'b1;
        winner = TAG_W'(i);
      end
    end
    gnt = '0;
    for (int i = 0; i < NREQ; i++) begin
      gnt[i] = en && hit && (winner == TAG_W'(i));
    end
  end

endmodule

// File: rtl/rs_pipe_sched.sv
// rtl/rs_pipe_sched.sv - round-robin scheduler feeding a shared DEPTH-stage register pipeline
module rs_pipe_sched
  import rs_pkg::*;
#(
  parameter int  WIDTH = DEF_WIDTH,
  parameter int  DEPTH = DEF_DEPTH,
  parameter int  NREQ  = 2,
  localparam int TAG_W = tag_w(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       grant,
  input  logic                  flush,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  state_t             state_q, state_d;
  logic [DEPTH-1:0]   stg_v;
  logic [WIDTH-1:0]   stg_d [DEPTH];
  logic [TAG_W-1:0]   stg_t [DEPTH];
  logic [TAG_W-1:0]   ptr_q;
  logic [TAG_W-1:0]   winner;
  logic [CNT_W-1:0]   occ;
  logic               adv;
  logic               arb_en;
  logic               granted;

  assign adv     = !stg_v[DEPTH-1] || out_ready;
  // Grant is held off during reset so requesters never see a phantom capture.
  assign arb_en  = rst_n && (state_q != DRAIN) && !flush && adv;
  assign granted = |grant;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req    (req),
    .ptr    (ptr_q),
    .en     (arb_en),
    .gnt    (grant),
    .winner (winner)
  );

  always_comb begin
    occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ = occ + CNT_W'(stg_v[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_v <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        stg_d[i] <= '0;
        stg_t[i] <= '0;
      end
    end else if (adv) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        stg_v[i] <= stg_v[i-1];
        stg_d[i] <= stg_d[i-1];
        stg_t[i] <= stg_t[i-1];
      end
      stg_v[0] <= granted;
      stg_d[0] <= granted ? req_data[int'(winner)*WIDTH +: WIDTH] : '0;
      stg_t[0] <= granted ? winner : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (granted) begin
      ptr_q <= (winner == TAG_W'(NREQ - 1)) ? '0 : winner + TAG_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req && !flush) state_d = RUN;
      RUN: begin
        if (flush)                        state_d = DRAIN;
        else if (occ == '0 && req == '0)  state_d = IDLE;
      end
      DRAIN:   if (occ == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign out_valid = stg_v[DEPTH-1];
  assign out_data  = stg_d[DEPTH-1];
  assign out_tag   = stg_t[DEPTH-1];
  assign busy      = (state_q != IDLE);

endmodule
